mem_port_arbiter: RTL and testbench

Arbitrates one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port (I) and load/store port (D). Sits between the fetch/memory stages and the backing memory model, in place of separate instruction and data memories. Keeps one transaction outstanding. The D port has fixed priority, and a starvation counter guarantees fetch progress. Supports fetch-response cancellation on a taken branch.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the fetch port (I) and the load/store port (D), one transaction in flight.
// D has fixed priority; a starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants while a fetch is pending.
// Optional event counters are enabled with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_size,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts,
  output logic [15:0]       perf_flushed
`endif
);

  localparam int unsigned     CNT_W     = 4;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]       SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             owner_d;
  logic             flush_flag;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_rvalid_q;
  logic             grant_d;
  logic             grant_i;

  // Arbitration in IDLE: D first, unless the fetch port has been starved long enough
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(i_req && (starve_cnt == LIMIT))) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // A flush landing in the response cycle itself still kills the fetch pulse
  assign i_rvalid = i_rvalid_q && !i_flush;

  // Transaction FSM, latched backend command and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      flush_flag <= 1'b0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_size     <= '0;
      m_wdata    <= '0;
      i_rvalid_q <= 1'b0;
      i_rdata    <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_size  <= d_size;
            m_wdata <= d_wdata;
            m_req   <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
            if (i_req && (starve_cnt != LIMIT)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (grant_i) begin
            owner_d    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_size     <= SIZE_WORD;
            m_wdata    <= '0;
            m_req      <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state <= RESP;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_we ? '0 : m_rdata;
            end else begin
              i_rvalid_q <= !(flush_flag || i_flush);
              i_rdata    <= m_rdata;
            end
          end
        end
        RESP: begin
          i_rvalid_q <= 1'b0;
          d_rvalid   <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Flush only matters for an in-flight fetch; cleared on the way back to IDLE
      if (state == RESP) begin
        flush_flag <= 1'b0;
      end else if ((state != IDLE) && !owner_d && i_flush) begin
        flush_flag <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Wrapping event counters: grants, IDLE conflicts, suppressed fetch responses
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
      perf_flushed   <= '0;
    end else begin
      if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
      if ((state == IDLE) && i_req && d_req) perf_conflicts <= perf_conflicts + 32'd1;
      if ((state == RESP) && !owner_d && (flush_flag || i_flush)) begin
        perf_flushed <= perf_flushed + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 0, i_flush = 0, d_req = 0, d_we = 0, m_ready = 0, m_rvalid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [1:0]  d_size = 0;
  logic i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
  logic [15:0] perf_flushed;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_m_req"}, 32'(m_req), 32'd0);
    chk({tag, "_m_we"}, 32'(m_we), 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'd0);
    chk({tag, "_m_size"}, 32'(m_size), 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 0; i_flush = 0; d_req = 0; d_we = 0; m_ready = 0; m_rvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_i_ready", 32'(i_ready), 32'd0);
    chk("reset_d_ready", 32'(d_ready), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("reset_perf_i", perf_i_grants, 32'd0);
    chk("reset_perf_d", perf_d_grants, 32'd0);
    chk("reset_perf_conf", perf_conflicts, 32'd0);
    chk("reset_perf_fl", 32'(perf_flushed), 32'd0);
`endif
  endtask

  typedef struct {
    logic        i_req, d_req, d_we, fl;
    logic [1:0]  d_size;
    logic [31:0] i_addr, d_addr, d_wdata, be_rdata;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];

  // One transaction at minimum latency: accept N, m_req N+1, rvalid N+3, idle N+4
  task automatic run_vec(input vec_t v, input int idx);
    drive_slot();
    i_req = v.i_req; i_addr = v.i_addr; i_flush = v.fl;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_size = v.d_size; d_wdata = v.d_wdata;
    @(negedge clk);
    chk($sformatf("v%0d_i_ready", idx), 32'(i_ready), 32'(!v.exp_d));
    chk($sformatf("v%0d_d_ready", idx), 32'(d_ready), 32'(v.exp_d));
    drive_slot();
    i_req = 0; d_req = 0; i_flush = 0; m_ready = 1;
    @(negedge clk);
    chk($sformatf("v%0d_m_req", idx), 32'(m_req), 32'd1);
    chk($sformatf("v%0d_m_addr", idx), m_addr, v.exp_addr);
    chk($sformatf("v%0d_m_we", idx), 32'(m_we), 32'(v.exp_we));
    chk($sformatf("v%0d_m_size", idx), 32'(m_size), 32'(v.exp_size));
    if (v.exp_we) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.d_wdata);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    drive_slot();
    m_ready = 0; m_rvalid = 1; m_rdata = v.be_rdata;
    @(negedge clk);
    chk($sformatf("v%0d_m_req_drop", idx), 32'(m_req), 32'd0);
    drive_slot();
    m_rvalid = 0; m_rdata = 0;
    @(negedge clk);
    chk($sformatf("v%0d_i_rvalid", idx), 32'(i_rvalid), 32'(!v.exp_d));
    chk($sformatf("v%0d_d_rvalid", idx), 32'(d_rvalid), 32'(v.exp_d));
    if (v.exp_d) chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_rdata);
    else         chk($sformatf("v%0d_i_rdata", idx), i_rdata, v.exp_rdata);
    drive_slot();
    @(negedge clk);
    chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_rvalid_end", idx), 32'(i_rvalid | d_rvalid), 32'd0);
  endtask

  // Transaction-level reference state for the random phase
  bit          act, x_isd, x_we, flushed, be_wait, i_drop, d_drop, wd, wi;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic [1:0]  x_size;
  int          t_rdy, t_rv, starve, be_cnt;
  int          m_ig, m_dg, m_conf, m_fl;

  initial begin
    vt[0] = '{1,0,0,0, 2'd0, 32'h0100_0000, 32'h0, 32'h0, 32'h0050_0093,
              0, 32'h0100_0000, 0, 2'd2, 32'h0050_0093};
    vt[1] = '{1,1,0,0, 2'd0, 32'h0100_0004, 32'h0100_0100, 32'h0, 32'h0000_00A5,
              1, 32'h0100_0100, 0, 2'd0, 32'h0000_00A5};
    vt[2] = '{1,0,0,1, 2'd0, 32'h0100_0004, 32'h0, 32'h0, 32'h00A0_0113,
              0, 32'h0100_0004, 0, 2'd2, 32'h00A0_0113};
    vt[3] = '{0,1,1,0, 2'd1, 32'h0, 32'h0100_0200, 32'h0000_ABCD, 32'h1234_5678,
              1, 32'h0100_0200, 1, 2'd1, 32'h0};
    for (int k = 0; k < 4; k++) begin
      vt[4+k] = '{1,1,0,0, 2'd2, 32'h0100_0008, 32'h0100_0300 + 32'(4*k), 32'h0,
                  32'h0000_1000 + 32'(k), 1, 32'h0100_0300 + 32'(4*k), 0, 2'd2,
                  32'h0000_1000 + 32'(k)};
    end
    vt[8] = '{1,1,0,0, 2'd2, 32'h0100_0008, 32'h0100_0400, 32'h0, 32'h00C0_0193,
              0, 32'h0100_0008, 0, 2'd2, 32'h00C0_0193};
    vt[9] = '{1,1,0,0, 2'd1, 32'h0100_000C, 32'h0100_0500, 32'h0, 32'h0000_BEEF,
              1, 32'h0100_0500, 0, 2'd1, 32'h0000_BEEF};

    do_reset();
    for (int k = 0; k < 10; k++) run_vec(vt[k], k);
`ifdef MEM_ARB_PERF_EN
    chk("perf_i_grants_tbl", perf_i_grants, 32'd3);
    chk("perf_d_grants_tbl", perf_d_grants, 32'd7);
    chk("perf_conflicts_tbl", perf_conflicts, 32'd7);
`endif

    // Flush pulsed in WAIT: response swallowed, FSM returns to IDLE on time
    drive_slot(); i_req = 1; i_addr = 32'h0100_0010;
    @(negedge clk); chk("fl_i_ready", 32'(i_ready), 32'd1);
    drive_slot(); i_req = 0; m_ready = 1;
    @(negedge clk); chk("fl_m_req", 32'(m_req), 32'd1);
    drive_slot(); m_ready = 0; i_flush = 1;
    @(negedge clk);
    drive_slot(); i_flush = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    drive_slot(); m_rvalid = 0;
    @(negedge clk);
    chk("fl_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("fl_busy_resp", 32'(busy), 32'd1);
    drive_slot();
    @(negedge clk);
    chk("fl_busy_idle", 32'(busy), 32'd0);
    chk("fl_i_rvalid_late", 32'(i_rvalid), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("fl_perf_flushed", 32'(perf_flushed), 32'd1);
`endif
    run_vec('{1,0,0,0, 2'd0, 32'h0100_0014, 32'h0, 32'h0, 32'h0000_0013,
              0, 32'h0100_0014, 0, 2'd2, 32'h0000_0013}, 10);

    // Store with m_ready held off 3 cycles: command must stay stable
    drive_slot(); d_req = 1; d_we = 1; d_size = 2'd1; d_addr = 32'h0100_0600; d_wdata = 32'h0000_ABCD;
    @(negedge clk); chk("st_d_ready", 32'(d_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive_slot(); d_req = 0; d_wdata = 32'h5555_5555; d_addr = 32'h0; m_ready = (k == 3);
      @(negedge clk);
      chk($sformatf("st_m_req_%0d", k), 32'(m_req), 32'd1);
      chk($sformatf("st_m_we_%0d", k), 32'(m_we), 32'd1);
      chk($sformatf("st_m_size_%0d", k), 32'(m_size), 32'd1);
      chk($sformatf("st_m_addr_%0d", k), m_addr, 32'h0100_0600);
      chk($sformatf("st_m_wdata_%0d", k), m_wdata, 32'h0000_ABCD);
    end
    drive_slot(); m_ready = 0;
    @(negedge clk); chk("st_m_req_drop", 32'(m_req), 32'd0);
    drive_slot(); @(negedge clk);
    drive_slot(); m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    drive_slot(); m_rvalid = 0;
    @(negedge clk);
    chk("st_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("st_d_rdata", d_rdata, 32'd0);
    chk("st_i_rvalid", 32'(i_rvalid), 32'd0);
    drive_slot(); d_we = 0;
    @(negedge clk);
    chk("st_d_rvalid_end", 32'(d_rvalid), 32'd0);
    chk("st_busy_end", 32'(busy), 32'd0);

    // Reset while in WAIT, late m_rvalid must be ignored
    drive_slot(); i_req = 1; i_addr = 32'h0100_0020;
    @(negedge clk); chk("rs_i_ready", 32'(i_ready), 32'd1);
    drive_slot(); i_req = 0; m_ready = 1;
    @(negedge clk);
    drive_slot(); m_ready = 0; rst = 1;
    @(negedge clk); chk("rs_busy_wait", 32'(busy), 32'd1);
    drive_slot(); rst = 0; m_rvalid = 1; m_rdata = 32'hCAFE_F00D;
    @(negedge clk); chk_all_zero("rs_after");
    drive_slot(); m_rvalid = 0;
    @(negedge clk); chk_all_zero("rs_after2");
    drive_slot(); i_req = 1; i_addr = 32'h0100_0024;
    @(negedge clk); chk("rs_idle_accept", 32'(i_ready), 32'd1);

    // Randomized traffic against the transaction-level model
    do_reset();
    act = 0; starve = 0; be_wait = 0; i_drop = 0; d_drop = 0;
    m_ig = 0; m_dg = 0; m_conf = 0; m_fl = 0;
    for (int c = 0; c < 4000; c++) begin
      drive_slot();
      if (i_drop) begin i_req = 0; i_drop = 0; end
      if (d_drop) begin d_req = 0; d_drop = 0; end
      if (!i_req && $urandom_range(0, 99) < 40) begin
        i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 99) < 50) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_flush = ($urandom_range(0, 99) < 15);
      m_ready = m_req && ($urandom_range(0, 99) < 60);
      m_rvalid = 0;
      if (be_wait) begin
        if (be_cnt == 0) begin m_rvalid = 1; m_rdata = $urandom; be_wait = 0; end
        else be_cnt--;
      end else if (!m_ready && $urandom_range(0, 99) < 5) begin
        m_rvalid = 1; m_rdata = $urandom;
      end
      @(negedge clk);
      if (!act) begin
        wd = d_req && !(i_req && starve == int'(STARVE_LIMIT));
        wi = i_req && !wd;
        chk("rnd_i_ready", 32'(i_ready), 32'(wi));
        chk("rnd_d_ready", 32'(d_ready), 32'(wd));
        chk("rnd_busy_idle", 32'(busy), 32'd0);
        chk("rnd_m_req_idle", 32'(m_req), 32'd0);
        chk("rnd_rvalid_idle", 32'(i_rvalid | d_rvalid), 32'd0);
        if (i_req && d_req) m_conf++;
        if (wd || wi) begin
          act = 1; t_rdy = -1; t_rv = -1; flushed = 0; x_isd = wd;
          x_we = wd ? d_we : 1'b0;
          x_size = wd ? d_size : 2'd2;
          x_addr = wd ? d_addr : i_addr;
          x_wdata = d_wdata;
        end
        if (wd) begin
          m_dg++; d_drop = 1;
          if (i_req && starve < int'(STARVE_LIMIT)) starve++;
        end else if (wi) begin
          m_ig++; i_drop = 1; starve = 0;
        end
      end else begin
        chk("rnd_ready_busy", 32'(i_ready | d_ready), 32'd0);
        chk("rnd_busy", 32'(busy), 32'd1);
        if (t_rdy < 0) begin
          chk("rnd_m_req", 32'(m_req), 32'd1);
          chk("rnd_m_addr", m_addr, x_addr);
          chk("rnd_m_we", 32'(m_we), 32'(x_we));
          chk("rnd_m_size", 32'(m_size), 32'(x_size));
          if (x_we) chk("rnd_m_wdata", m_wdata, x_wdata);
          if (m_ready) begin t_rdy = c; be_wait = 1; be_cnt = $urandom_range(0, 2); end
        end else begin
          chk("rnd_m_req_low", 32'(m_req), 32'd0);
        end
        if (!x_isd && i_flush) flushed = 1;
        if (t_rv >= 0 && c == t_rv + 1) begin
          chk("rnd_i_rvalid", 32'(i_rvalid), 32'(!x_isd && !flushed));
          chk("rnd_d_rvalid", 32'(d_rvalid), 32'(x_isd));
          if (x_isd) chk("rnd_d_rdata", d_rdata, x_we ? 32'd0 : x_rdata);
          else if (!flushed) chk("rnd_i_rdata", i_rdata, x_rdata);
          if (!x_isd && flushed) m_fl++;
          act = 0;
        end else begin
          chk("rnd_rvalid_quiet", 32'(i_rvalid | d_rvalid), 32'd0);
          if (t_rdy >= 0 && c > t_rdy && t_rv < 0 && m_rvalid) begin
            t_rv = c; x_rdata = m_rdata;
          end
        end
      end
    end
`ifdef MEM_ARB_PERF_EN
    chk("rnd_perf_i", perf_i_grants, 32'(m_ig));
    chk("rnd_perf_d", perf_d_grants, 32'(m_dg));
    chk("rnd_perf_conf", perf_conflicts, 32'(m_conf));
    chk("rnd_perf_fl", 32'(perf_flushed), 32'(m_fl));
`endif
    chk("rnd_saw_i_grants", 32'(m_ig > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
